// File: rtl/spm_arbiter_pkg.sv
// Shared definitions for the SPM single-port arbiter: widths, read-owner
// encoding and the strobe/direction constants used by the pipeline.
package spm_arbiter_pkg;

    localparam int SPM_ADDR_W = 12;
    localparam int SPM_DATA_W = 32;

    typedef logic [1:0] spm_own_t;

    localparam spm_own_t SPM_OWN_NONE = 2'd0;
    localparam spm_own_t SPM_OWN_IF   = 2'd1;
    localparam spm_own_t SPM_OWN_MEM  = 2'd2;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    function automatic logic spm_is_req(input logic as_n);
        return (as_n == ENABLE_);
    endfunction

endpackage

// File: rtl/spm_arbiter_rd_ret.sv
// spm_rd_ret: per-requester read return path. Shows RAM data in the cycle
// the requester owns the returning read, and holds it afterwards.
module spm_rd_ret
    import spm_arbiter_pkg::*;
#(
    parameter int DATA_W = SPM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel_i,
    input  logic [DATA_W-1:0] ram_rd_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_vld_o
);

    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] hold_d;

    // Return mux; reset hides an in-flight read and the stale hold value
    always_comb begin
        rd_vld_o = sel_i & ~reset;
        hold_d   = hold_q;
        if (sel_i) begin
            hold_d = ram_rd_data_i;
        end else begin
            hold_d = hold_q;
        end
        if (reset) begin
            rd_data_o = {DATA_W{1'b0}};
        end else if (sel_i) begin
            rd_data_o = ram_rd_data_i;
        end else begin
            rd_data_o = hold_q;
        end
    end

    // Hold register
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= {DATA_W{1'b0}};
        end else begin
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/spm_arbiter.sv
// spm_arbiter: shares one synchronous-read SPM port between IF and MEM.
// Macro SPM_ARB_FAIR_EN enables the IF anti-starvation counter.
module spm_arbiter
    import spm_arbiter_pkg::*;
#(
    parameter int ADDR_W     = SPM_ADDR_W,
    parameter int DATA_W     = SPM_DATA_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_spm_addr,
    input  logic              if_spm_as_,
    input  logic              if_spm_rw,
    input  logic [DATA_W-1:0] if_spm_wr_data,
    output logic [DATA_W-1:0] if_spm_rd_data,
    output logic              if_spm_rd_vld,
    output logic              if_spm_busy,
    input  logic [ADDR_W-1:0] mem_spm_addr,
    input  logic              mem_spm_as_,
    input  logic              mem_spm_rw,
    input  logic [DATA_W-1:0] mem_spm_wr_data,
    output logic [DATA_W-1:0] mem_spm_rd_data,
    output logic              mem_spm_rd_vld,
    output logic              mem_spm_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_rd_data
);

    logic     if_req_s, mem_req_s;
    logic     if_gnt_s, mem_gnt_s;
    logic     force_if_s;
    logic     if_sel_s, mem_sel_s;
    spm_own_t rd_owner_q, rd_owner_d;

    // Raw requests (strobes are active low)
    always_comb begin
        if_req_s  = spm_is_req(if_spm_as_);
        mem_req_s = spm_is_req(mem_spm_as_);
    end

`ifdef SPM_ARB_FAIR_EN
    localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

    logic [1:0] starve_cnt_q, starve_cnt_d;

    // IF overrides MEM once it has lost STARVE_MAX cycles in a row
    always_comb begin
        force_if_s = if_req_s & (starve_cnt_q == STARVE_LIM);
    end

    // Saturating count of consecutive IF losses
    always_comb begin
        if (if_req_s && !if_gnt_s) begin
            if (starve_cnt_q != 2'd3) begin
                starve_cnt_d = starve_cnt_q + 2'd1;
            end else begin
                starve_cnt_d = starve_cnt_q;
            end
        end else begin
            starve_cnt_d = 2'd0;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= 2'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Strict MEM priority
    always_comb begin
        force_if_s = 1'b0;
    end
`endif

    // Grant: MEM holds the older instruction, so it wins unless IF is starved
    always_comb begin
        if (reset) begin
            if_gnt_s  = 1'b0;
            mem_gnt_s = 1'b0;
        end else begin
            mem_gnt_s = mem_req_s & ~force_if_s;
            if_gnt_s  = if_req_s & (~mem_req_s | force_if_s);
        end
    end

    // RAM port drive and owner of the read issued this cycle
    always_comb begin
        ram_addr    = {ADDR_W{1'b0}};
        ram_wr_data = {DATA_W{1'b0}};
        ram_wren    = 1'b0;
        rd_owner_d  = SPM_OWN_NONE;
        case ({if_gnt_s, mem_gnt_s})
            2'b10: begin
                ram_addr    = if_spm_addr;
                ram_wr_data = if_spm_wr_data;
                ram_wren    = (if_spm_rw == WRITE);
                rd_owner_d  = (if_spm_rw == READ) ? SPM_OWN_IF : SPM_OWN_NONE;
            end
            2'b01: begin
                ram_addr    = mem_spm_addr;
                ram_wr_data = mem_spm_wr_data;
                ram_wren    = (mem_spm_rw == WRITE);
                rd_owner_d  = (mem_spm_rw == READ) ? SPM_OWN_MEM : SPM_OWN_NONE;
            end
            default: begin
                rd_owner_d = SPM_OWN_NONE;
            end
        endcase
    end

    // Stall the loser; busy always follows the raw request
    always_comb begin
        if_spm_busy  = if_req_s & ~if_gnt_s;
        mem_spm_busy = mem_req_s & ~mem_gnt_s;
        if_sel_s     = (rd_owner_q == SPM_OWN_IF);
        mem_sel_s    = (rd_owner_q == SPM_OWN_MEM);
    end

    // Read owner register
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner_q <= SPM_OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    spm_rd_ret #(.DATA_W(DATA_W)) u_if_ret (
        .clk           (clk),
        .reset         (reset),
        .sel_i         (if_sel_s),
        .ram_rd_data_i (ram_rd_data),
        .rd_data_o     (if_spm_rd_data),
        .rd_vld_o      (if_spm_rd_vld)
    );

    spm_rd_ret #(.DATA_W(DATA_W)) u_mem_ret (
        .clk           (clk),
        .reset         (reset),
        .sel_i         (mem_sel_s),
        .ram_rd_data_i (ram_rd_data),
        .rd_data_o     (mem_spm_rd_data),
        .rd_vld_o      (mem_spm_rd_vld)
    );

endmodule

// File: tb/tb_spm_arbiter.sv
// Self-checking bench for spm_arbiter: directed scenarios plus randomized
// traffic against a cycle-level behavioural model and a shadow memory.
module tb_spm_arbiter;

`ifdef SPM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam int   T_STARVE = 3;
    localparam logic T_RD     = 1'b1;
    localparam logic T_WR     = 1'b0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] if_spm_addr = 12'h000, mem_spm_addr = 12'h000, ram_addr;
    logic        if_spm_as_ = 1'b1, if_spm_rw = 1'b1, mem_spm_as_ = 1'b1, mem_spm_rw = 1'b1;
    logic [31:0] if_spm_wr_data = 32'h0, mem_spm_wr_data = 32'h0;
    logic [31:0] if_spm_rd_data, mem_spm_rd_data, ram_wr_data;
    logic [31:0] ram_rd_data = 32'h0;
    logic        if_spm_rd_vld, if_spm_busy, mem_spm_rd_vld, mem_spm_busy, ram_wren;

    logic [31:0] ram     [0:4095];
    logic [31:0] ref_mem [0:4095];

    int n_vec = 0;
    int n_err = 0;

    // model state
    int          e_gnt, pend_own, starve;
    bit          m_ifr, m_mr;
    logic [11:0] e_addr;
    logic [31:0] e_wdata, pend_data, if_hold, mem_hold, e_if_data, e_mem_data;
    logic        e_wren, e_if_busy, e_mem_busy, e_if_vld, e_mem_vld;

    spm_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .if_spm_addr     (if_spm_addr),
        .if_spm_as_      (if_spm_as_),
        .if_spm_rw       (if_spm_rw),
        .if_spm_wr_data  (if_spm_wr_data),
        .if_spm_rd_data  (if_spm_rd_data),
        .if_spm_rd_vld   (if_spm_rd_vld),
        .if_spm_busy     (if_spm_busy),
        .mem_spm_addr    (mem_spm_addr),
        .mem_spm_as_     (mem_spm_as_),
        .mem_spm_rw      (mem_spm_rw),
        .mem_spm_wr_data (mem_spm_wr_data),
        .mem_spm_rd_data (mem_spm_rd_data),
        .mem_spm_rd_vld  (mem_spm_rd_vld),
        .mem_spm_busy    (mem_spm_busy),
        .ram_addr        (ram_addr),
        .ram_wr_data     (ram_wr_data),
        .ram_wren        (ram_wren),
        .ram_rd_data     (ram_rd_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM environment
    always @(posedge clk) begin
        if (ram_wren) ram[ram_addr] <= ram_wr_data;
        ram_rd_data <= ram[ram_addr];
    end

    // Expected combinational view of the current cycle
    task automatic model_pre();
        m_ifr = !reset && !if_spm_as_;
        m_mr  = !reset && !mem_spm_as_;
        if (m_ifr && m_mr) e_gnt = (FAIR && starve >= T_STARVE) ? 1 : 2;
        else if (m_ifr)    e_gnt = 1;
        else if (m_mr)     e_gnt = 2;
        else               e_gnt = 0;
        e_addr  = (e_gnt == 1) ? if_spm_addr : (e_gnt == 2) ? mem_spm_addr : 12'h000;
        e_wdata = (e_gnt == 1) ? if_spm_wr_data : mem_spm_wr_data;
        e_wren  = (e_gnt == 1 && if_spm_rw == T_WR) || (e_gnt == 2 && mem_spm_rw == T_WR);
        e_if_busy  = !if_spm_as_  && e_gnt != 1;
        e_mem_busy = !mem_spm_as_ && e_gnt != 2;
        e_if_vld   = !reset && pend_own == 1;
        e_mem_vld  = !reset && pend_own == 2;
        e_if_data  = reset ? 32'h0 : (pend_own == 1 ? pend_data : if_hold);
        e_mem_data = reset ? 32'h0 : (pend_own == 2 ? pend_data : mem_hold);
    endtask

    // Advance the model across the clock edge ending the current cycle
    task automatic model_post();
        if (reset) begin
            pend_own = 0; if_hold = 32'h0; mem_hold = 32'h0; starve = 0;
        end else begin
            if (pend_own == 1) if_hold = pend_data;
            if (pend_own == 2) mem_hold = pend_data;
            if (e_wren) ref_mem[e_addr] = e_wdata;
            if (e_gnt != 0 && !e_wren) begin
                pend_own  = e_gnt;
                pend_data = ref_mem[e_addr];
            end else begin
                pend_own = 0;
            end
            if (m_ifr && e_gnt != 1) starve = (starve < 3) ? starve + 1 : 3;
            else                     starve = 0;
        end
    endtask

    task automatic tick(input logic rst,
                        input logic [11:0] ia, input logic ias, input logic irw, input logic [31:0] iwd,
                        input logic [11:0] ma, input logic mas, input logic mrw, input logic [31:0] mwd);
        @(posedge clk);
        model_post();
        #1;
        reset = rst;
        if_spm_addr = ia;  if_spm_as_ = ias;  if_spm_rw = irw;  if_spm_wr_data = iwd;
        mem_spm_addr = ma; mem_spm_as_ = mas; mem_spm_rw = mrw; mem_spm_wr_data = mwd;
        model_pre();
        @(negedge clk);
    endtask

    task automatic tick_idle();
        tick(1'b0, 12'h000, 1'b1, T_RD, 32'h0, 12'h000, 1'b1, T_RD, 32'h0);
    endtask

    task automatic test_reset();
        tick(1'b1, 12'h00a, 1'b0, T_RD, 32'h0, 12'h00b, 1'b0, T_WR, 32'h1);
        n_vec += 6;
        if (ram_wren !== 1'b0) begin n_err++; $display("FAIL rst_wren: got %b want 0", ram_wren); end
        if (ram_addr !== 12'h000) begin n_err++; $display("FAIL rst_addr: got %h want 000", ram_addr); end
        if (if_spm_busy !== 1'b1 || mem_spm_busy !== 1'b1) begin
            n_err++; $display("FAIL rst_busy: got %b%b want 11", if_spm_busy, mem_spm_busy); end
        if (if_spm_rd_vld !== 1'b0 || mem_spm_rd_vld !== 1'b0) begin
            n_err++; $display("FAIL rst_vld: got %b%b want 00", if_spm_rd_vld, mem_spm_rd_vld); end
        if (if_spm_rd_data !== 32'h0) begin n_err++; $display("FAIL rst_if_data: got %h want 0", if_spm_rd_data); end
        if (mem_spm_rd_data !== 32'h0) begin n_err++; $display("FAIL rst_mem_data: got %h want 0", mem_spm_rd_data); end
        tick(1'b1, 12'h000, 1'b1, T_RD, 32'h0, 12'h000, 1'b1, T_RD, 32'h0);
        n_vec++;
        if (if_spm_busy !== 1'b0 || mem_spm_busy !== 1'b0) begin
            n_err++; $display("FAIL rst_busy_idle: got %b%b want 00", if_spm_busy, mem_spm_busy); end
        tick_idle();
    endtask

    task automatic test_if_read();
        ram[12'h010] = 32'hDEADBEEF; ref_mem[12'h010] = 32'hDEADBEEF;
        tick(1'b0, 12'h010, 1'b0, T_RD, 32'h0, 12'h000, 1'b1, T_RD, 32'h0);
        n_vec += 2;
        if (ram_addr !== 12'h010) begin n_err++; $display("FAIL ifrd_addr: got %h want 010", ram_addr); end
        if (if_spm_busy !== 1'b0) begin n_err++; $display("FAIL ifrd_busy: got %b want 0", if_spm_busy); end
        tick_idle();
        n_vec += 3;
        if (if_spm_rd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL ifrd_data: got %h want deadbeef", if_spm_rd_data); end
        if (if_spm_rd_vld !== 1'b1) begin n_err++; $display("FAIL ifrd_vld: got %b want 1", if_spm_rd_vld); end
        if (mem_spm_rd_vld !== 1'b0) begin n_err++; $display("FAIL ifrd_memvld: got %b want 0", mem_spm_rd_vld); end
    endtask

    task automatic test_conflict();
        tick(1'b0, 12'h020, 1'b0, T_RD, 32'h0, 12'h030, 1'b0, T_WR, 32'h5A5A5A5A);
        n_vec += 4;
        if (ram_wren !== 1'b1) begin n_err++; $display("FAIL cf_wren: got %b want 1", ram_wren); end
        if (ram_addr !== 12'h030) begin n_err++; $display("FAIL cf_addr: got %h want 030", ram_addr); end
        if (ram_wr_data !== 32'h5A5A5A5A) begin n_err++; $display("FAIL cf_wdata: got %h want 5a5a5a5a", ram_wr_data); end
        if (if_spm_busy !== 1'b1 || mem_spm_busy !== 1'b0) begin
            n_err++; $display("FAIL cf_busy: got %b%b want 10", if_spm_busy, mem_spm_busy); end
        tick(1'b0, 12'h020, 1'b0, T_RD, 32'h0, 12'h000, 1'b1, T_RD, 32'h0);
        n_vec += 3;
        if (ram_addr !== 12'h020) begin n_err++; $display("FAIL cf_ifaddr: got %h want 020", ram_addr); end
        if (if_spm_busy !== 1'b0) begin n_err++; $display("FAIL cf_ifbusy: got %b want 0", if_spm_busy); end
        if (mem_spm_rd_vld !== 1'b0) begin n_err++; $display("FAIL cf_wr_novld: got %b want 0", mem_spm_rd_vld); end
        tick_idle();
        n_vec += 2;
        if (if_spm_rd_vld !== 1'b1) begin n_err++; $display("FAIL cf_ifvld: got %b want 1", if_spm_rd_vld); end
        if (if_spm_rd_data !== e_if_data) begin n_err++; $display("FAIL cf_ifdata: got %h want %h", if_spm_rd_data, e_if_data); end
    endtask

    task automatic test_write_read();
        tick(1'b0, 12'h000, 1'b1, T_RD, 32'h0, 12'h040, 1'b0, T_WR, 32'h12345678);
        tick(1'b0, 12'h000, 1'b1, T_RD, 32'h0, 12'h040, 1'b0, T_RD, 32'h0);
        tick_idle();
        n_vec += 2;
        if (mem_spm_rd_data !== 32'h12345678) begin n_err++; $display("FAIL wr_rd_data: got %h want 12345678", mem_spm_rd_data); end
        if (mem_spm_rd_vld !== 1'b1) begin n_err++; $display("FAIL wr_rd_vld: got %b want 1", mem_spm_rd_vld); end
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 12'h001, 1'b0, T_RD, 32'h0, 12'h000, 1'b1, T_RD, 32'h0);
        tick(1'b0, 12'h000, 1'b1, T_RD, 32'h0, 12'h002, 1'b0, T_RD, 32'h0);
        n_vec += 3;
        if (if_spm_rd_vld !== 1'b1 || mem_spm_rd_vld !== 1'b0) begin
            n_err++; $display("FAIL b2b_1_vld: got %b%b want 10", if_spm_rd_vld, mem_spm_rd_vld); end
        if (if_spm_rd_data !== ref_mem[12'h001]) begin n_err++; $display("FAIL b2b_1_data: got %h want %h", if_spm_rd_data, ref_mem[12'h001]); end
        if (mem_spm_rd_data !== e_mem_data) begin n_err++; $display("FAIL b2b_1_memhold: got %h want %h", mem_spm_rd_data, e_mem_data); end
        tick(1'b0, 12'h003, 1'b0, T_RD, 32'h0, 12'h000, 1'b1, T_RD, 32'h0);
        n_vec += 3;
        if (if_spm_rd_vld !== 1'b0 || mem_spm_rd_vld !== 1'b1) begin
            n_err++; $display("FAIL b2b_2_vld: got %b%b want 01", if_spm_rd_vld, mem_spm_rd_vld); end
        if (mem_spm_rd_data !== ref_mem[12'h002]) begin n_err++; $display("FAIL b2b_2_data: got %h want %h", mem_spm_rd_data, ref_mem[12'h002]); end
        if (if_spm_rd_data !== ref_mem[12'h001]) begin n_err++; $display("FAIL b2b_2_ifhold: got %h want %h", if_spm_rd_data, ref_mem[12'h001]); end
        tick_idle();
        n_vec += 3;
        if (if_spm_rd_vld !== 1'b1 || mem_spm_rd_vld !== 1'b0) begin
            n_err++; $display("FAIL b2b_3_vld: got %b%b want 10", if_spm_rd_vld, mem_spm_rd_vld); end
        if (if_spm_rd_data !== ref_mem[12'h003]) begin n_err++; $display("FAIL b2b_3_data: got %h want %h", if_spm_rd_data, ref_mem[12'h003]); end
        if (mem_spm_rd_data !== ref_mem[12'h002]) begin n_err++; $display("FAIL b2b_3_memhold: got %h want %h", mem_spm_rd_data, ref_mem[12'h002]); end
        tick_idle();
        n_vec++;
        if (if_spm_rd_vld !== 1'b0 || mem_spm_rd_vld !== 1'b0) begin
            n_err++; $display("FAIL b2b_once: got %b%b want 00", if_spm_rd_vld, mem_spm_rd_vld); end
    endtask

    task automatic test_fairness();
        int first = -1;
        tick_idle();
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, 12'h100, 1'b0, T_RD, 32'h0, 12'h200 + 12'(c), 1'b0, T_RD, 32'h0);
            n_vec++;
            if (ram_addr !== e_addr) begin n_err++; $display("FAIL fair_addr c%0d: got %h want %h", c, ram_addr, e_addr); end
            if (first < 0 && if_spm_busy === 1'b0) first = c;
        end
        n_vec++;
        if (first != (FAIR ? 3 : -1)) begin
            n_err++; $display("FAIL fair_first_if_grant: got %0d want %0d", first, FAIR ? 3 : -1); end
        tick_idle();
        tick_idle();
    endtask

    task automatic test_reset_mid_read();
        tick(1'b0, 12'h050, 1'b0, T_RD, 32'h0, 12'h000, 1'b1, T_RD, 32'h0);
        tick(1'b1, 12'h050, 1'b0, T_RD, 32'h0, 12'h000, 1'b1, T_RD, 32'h0);
        n_vec += 4;
        if (if_spm_rd_vld !== 1'b0) begin n_err++; $display("FAIL midrst_vld: got %b want 0", if_spm_rd_vld); end
        if (if_spm_rd_data !== 32'h0) begin n_err++; $display("FAIL midrst_data: got %h want 0", if_spm_rd_data); end
        if (ram_wren !== 1'b0) begin n_err++; $display("FAIL midrst_wren: got %b want 0", ram_wren); end
        if (if_spm_busy !== 1'b1 || mem_spm_busy !== 1'b0) begin
            n_err++; $display("FAIL midrst_busy: got %b%b want 10", if_spm_busy, mem_spm_busy); end
        tick_idle();
        n_vec++;
        if (if_spm_rd_vld !== 1'b0 || if_spm_rd_data !== 32'h0) begin
            n_err++; $display("FAIL midrst_after: got %b/%h want 0/0", if_spm_rd_vld, if_spm_rd_data); end
    endtask

    task automatic test_random();
        logic [11:0] ia = 12'h0, ma = 12'h0;
        logic        ias = 1'b1, irw = 1'b1, mas = 1'b1, mrw = 1'b1;
        logic [31:0] iwd = 32'h0, mwd = 32'h0;
        for (int n = 0; n < 400; n++) begin
            if (!e_if_busy) begin
                ias = ($urandom_range(0, 2) == 0); irw = 1'($urandom_range(0, 1));
                ia = 12'($urandom_range(0, 15)); iwd = $urandom;
            end
            if (!e_mem_busy) begin
                mas = ($urandom_range(0, 2) == 0); mrw = 1'($urandom_range(0, 1));
                ma = 12'($urandom_range(0, 15)); mwd = $urandom;
            end
            tick(1'b0, ia, ias, irw, iwd, ma, mas, mrw, mwd);
            n_vec += 7;
            if (ram_addr !== e_addr || ram_wren !== e_wren) begin
                n_err++; $display("FAIL rnd_ram n%0d: got %h/%b want %h/%b", n, ram_addr, ram_wren, e_addr, e_wren); end
            if (e_gnt != 0 && ram_wr_data !== e_wdata) begin
                n_err++; $display("FAIL rnd_wdata n%0d: got %h want %h", n, ram_wr_data, e_wdata); end
            if (if_spm_busy !== e_if_busy || mem_spm_busy !== e_mem_busy) begin
                n_err++; $display("FAIL rnd_busy n%0d: got %b%b want %b%b", n, if_spm_busy, mem_spm_busy, e_if_busy, e_mem_busy); end
            if (if_spm_rd_vld !== e_if_vld) begin
                n_err++; $display("FAIL rnd_ifvld n%0d: got %b want %b", n, if_spm_rd_vld, e_if_vld); end
            if (mem_spm_rd_vld !== e_mem_vld) begin
                n_err++; $display("FAIL rnd_memvld n%0d: got %b want %b", n, mem_spm_rd_vld, e_mem_vld); end
            if (if_spm_rd_data !== e_if_data) begin
                n_err++; $display("FAIL rnd_ifdata n%0d: got %h want %h", n, if_spm_rd_data, e_if_data); end
            if (mem_spm_rd_data !== e_mem_data) begin
                n_err++; $display("FAIL rnd_memdata n%0d: got %h want %h", n, mem_spm_rd_data, e_mem_data); end
        end
    endtask

    initial begin
        pend_own = 0; starve = 0; e_gnt = 0; e_wren = 1'b0;
        e_if_busy = 1'b0; e_mem_busy = 1'b0;
        if_hold = 32'h0; mem_hold = 32'h0; pend_data = 32'h0;
        for (int a = 0; a < 4096; a++) begin
            ram[a] = $urandom;
            ref_mem[a] = ram[a];
        end
        test_reset();
        test_if_read();
        test_conflict();
        test_write_read();
        test_back_to_back();
        test_fairness();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
